truth_table_checker: RTL and testbench

- Synthesizable self-checking sequencer for 4-input, 1-output combinational blocks.
- On `start`, drives all 16 input combinations on {a,b,c,d} and holds each for a settle interval.
- Samples the DUT output `f_in` for each combination and compares it against a parameterised expected truth table.
- Reports error count, first failing index and pass/done status; used for on-board checks of the team's combinational exercises.

---
 rtl/truth_table_checker.sv | 112 +++++++++++
 tb/tb_truth_table_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Exhaustive sequencer for 4-input, 1-output combinational blocks.
// Sweeps {a,b,c,d}, samples f_in after a settle interval, and scores it against EXPECTED.
module truth_table_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [15:0] EXPECTED      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic        first_err_valid,
  output logic [3:0]  first_err_idx,
  output logic [15:0] captured
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  err_q, err_d;
  logic        fev_q, fev_d;
  logic [3:0]  fei_q, fei_d;
  logic [15:0] cap_q, cap_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fei_d   = fei_q;
    cap_d   = cap_q;
    unique case (1'b1)
      (state_q == IDLE),
      (state_q == DONE): begin
        if (start) begin
          state_d = SETTLE;
          idx_d   = 4'd0;
          cnt_d   = 8'd0;
          err_d   = 5'd0;
          fev_d   = 1'b0;
          fei_d   = 4'd0;
          cap_d   = 16'd0;
        end
      end
      (state_q == SETTLE): begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST) begin
          cap_d[idx_q] = f_in;
          if (f_in != EXPECTED[idx_q]) begin
            err_d = err_q + 5'd1;
            if (!fev_q) begin
              fev_d = 1'b1;
              fei_d = idx_q;
            end
          end
          // last vector scored on the same edge that leaves SETTLE
          if (idx_q == 4'hF) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 4'd1;
            cnt_d = 8'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 8'd0;
      err_q   <= 5'd0;
      fev_q   <= 1'b0;
      fei_q   <= 4'd0;
      cap_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
      cap_q   <= cap_d;
    end
  end

  assign {a, b, c, d}    = idx_q;
  assign busy            = (state_q == SETTLE);
  assign done            = (state_q == DONE);
  assign pass            = done && (err_q == 5'd0);
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;
  assign captured        = cap_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: scoreboarded runs at SETTLE=4,
// plus a vector-by-vector trace at SETTLE=1.
module tb_truth_table_checker;

  localparam logic [15:0] EXP = 16'hA5C3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start4, start1, f4, f1;
  int   mode;

  logic        a4, b4, c4, d4, busy4, done4, pass4, fev4;
  logic [4:0]  err4;
  logic [3:0]  fei4;
  logic [15:0] cap4;
  logic [3:0]  vec4;

  logic        a1, b1, c1, d1, busy1, done1, pass1, fev1;
  logic [4:0]  err1;
  logic [3:0]  fei1;
  logic [15:0] cap1;
  logic [3:0]  vec1;

  assign vec4 = {a4, b4, c4, d4};
  assign vec1 = {a1, b1, c1, d1};

  // mode 0: correct, 1: inverted, 2: wrong only at index 9
  always_comb f4 = EXP[vec4] ^ (mode == 1) ^ ((mode == 2) && (vec4 == 4'd9));
  always_comb f1 = EXP[vec1];

  truth_table_checker #(.SETTLE_CYCLES(4), .EXPECTED(EXP)) u_s4 (
    .clk(clk), .rst(rst), .start(start4), .f_in(f4),
    .a(a4), .b(b4), .c(c4), .d(d4),
    .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .first_err_valid(fev4),
    .first_err_idx(fei4), .captured(cap4)
  );

  truth_table_checker #(.SETTLE_CYCLES(1), .EXPECTED(EXP)) u_s1 (
    .clk(clk), .rst(rst), .start(start1), .f_in(f1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_valid(fev1),
    .first_err_idx(fei1), .captured(cap1)
  );

  typedef struct {
    logic [4:0]  err;
    logic        fev;
    logic [3:0]  fei;
    logic [15:0] cap;
    logic        pass;
    int          len;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, want);
  endtask

  // monitor: score each completed run against the queued expectation
  initial begin
    int   cnt;
    logic dp;
    exp_t e;
    cnt = 0;
    dp  = 1'b0;
    forever begin
      @(negedge clk);
      if (busy4) cnt++;
      else begin
        if (done4 && !dp) begin
          if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL sb_unexpected_done: got done expected none");
          end else begin
            e = sb.pop_front();
            chk("mon_len", cnt, e.len);
            chk("mon_err", err4, e.err);
            chk("mon_fev", fev4, e.fev);
            chk("mon_fei", fei4, e.fei);
            chk("mon_cap", cap4, e.cap);
            chk("mon_pass", pass4, e.pass);
          end
        end
        cnt = 0;
      end
      dp = done4;
    end
  end

  task automatic pulse4();
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
  endtask

  task automatic wait_done4(input string nm);
    int n;
    n = 0;
    while (!done4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done4) begin
      n_chk++;
      $display("FAIL %s_timeout: got done=0 expected done=1", nm);
    end
  endtask

  task automatic wait_vec4(input logic [3:0] v, input string nm);
    int n;
    n = 0;
    while (vec4 != v && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (vec4 != v) begin
      n_chk++;
      $display("FAIL %s_timeout: got vec=%0h expected %0h", nm, vec4, v);
    end
  endtask

  task automatic chk_reset4(input string nm);
    chk({nm, "_vec"}, vec4, 0);
    chk({nm, "_busy"}, busy4, 0);
    chk({nm, "_done"}, done4, 0);
    chk({nm, "_pass"}, pass4, 0);
    chk({nm, "_err"}, err4, 0);
    chk({nm, "_fev"}, fev4, 0);
    chk({nm, "_fei"}, fei4, 0);
    chk({nm, "_cap"}, cap4, 0);
  endtask

  task automatic run4(input int m, input exp_t e, input string nm);
    mode = m;
    sb.push_back(e);
    pulse4();
    @(negedge clk);
    chk({nm, "_busy"}, busy4, 1);
    chk({nm, "_done"}, done4, 0);
    chk({nm, "_err"}, err4, 0);
    chk({nm, "_cap"}, cap4, 0);
    chk({nm, "_vec"}, vec4, 0);
    wait_done4(nm);
  endtask

  exp_t ok_e, inv_e, one_e;

  initial begin
    ok_e  = '{5'd0,  1'b0, 4'd0, 16'hA5C3, 1'b1, 64};
    inv_e = '{5'd16, 1'b1, 4'd0, 16'h5A3C, 1'b0, 64};
    one_e = '{5'd1,  1'b1, 4'd9, 16'hA7C3, 1'b0, 64};

    rst = 1'b1; start4 = 1'b0; start1 = 1'b0; mode = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset4("rst0");
    chk("rst0_s1_busy", busy1, 0);

    run4(0, ok_e, "r1_ok");
    run4(1, inv_e, "r2_inv");
    run4(0, ok_e, "r3_restart");
    run4(2, one_e, "r4_idx9");

    // start during SETTLE must be ignored
    mode = 0;
    sb.push_back(ok_e);
    pulse4();
    wait_vec4(4'd5, "mid_wait");
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    chk("mid_vec", vec4, 5);
    chk("mid_busy", busy4, 1);
    wait_done4("mid");

    // abandon a failing run with reset
    mode = 1;
    pulse4();
    wait_vec4(4'd7, "rst_wait");
    chk("pre_rst_err", err4, 7);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset4("rst7");
    run4(0, ok_e, "r7_after_rst");

    // SETTLE_CYCLES=1: one vector per cycle
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      else @(negedge clk);
      chk($sformatf("s1_vec%0d", i), vec1, i);
      chk($sformatf("s1_busy%0d", i), busy1, 1);
    end
    @(negedge clk);
    chk("s1_done", done1, 1);
    chk("s1_cap", cap1, EXP);
    chk("s1_pass", pass1, 1);
    chk("s1_vec_end", vec1, 15);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
